// File: rtl/led_pattern_pkg.sv
// Shared types and constants for the LED pattern engine.
package led_pattern_pkg;

    localparam int unsigned MODE_W = 2;

    typedef enum logic [MODE_W-1:0] {
        MODE_OFF     = 2'd0,
        MODE_BLINK   = 2'd1,
        MODE_CHASE   = 2'd2,
        MODE_BREATHE = 2'd3
    } led_mode_e;

endpackage

// File: rtl/led_prescaler.sv
// Step-rate prescaler: counts enabled clocks 0..TICK_DIV-1 and flags the last count.
module led_prescaler #(
    parameter int unsigned TICK_DIV = 1_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic enable,
    output logic tick
);

    localparam int unsigned CNT_W = $clog2(TICK_DIV);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TICK_DIV - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Combinational so the top can register step and the LED update on the same edge.
    assign tick = enable && (cnt_q == CNT_MAX);

    always_comb begin
        cnt_d = cnt_q;
        if (enable) begin
            cnt_d = tick ? '0 : cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/led_pattern_gen.sv
// LED pattern engine: OFF / BLINK / CHASE / BREATHE driven by a prescaled step tick,
// with mode changes taken over valid/ready and applied on the next step tick.
module led_pattern_gen
    import led_pattern_pkg::*;
#(
    parameter int unsigned NUM_LEDS = 8,
    parameter int unsigned TICK_DIV = 1_000_000,
    parameter int unsigned PWM_W    = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                enable,
    input  logic [MODE_W-1:0]   mode,
    input  logic                mode_valid,
    output logic                mode_ready,
    output logic [NUM_LEDS-1:0] led,
    output logic                step
);

    localparam logic [PWM_W-1:0] DUTY_MAX = '1;

    logic tick;

    led_prescaler #(
        .TICK_DIV (TICK_DIV)
    ) u_prescaler (
        .clk    (clk),
        .rst    (rst),
        .enable (enable),
        .tick   (tick)
    );

    led_mode_e           mode_q,       mode_d;
    led_mode_e           pend_mode_q,  pend_mode_d;
    logic                pend_valid_q, pend_valid_d;
    logic                ready_q,      ready_d;
    logic                step_q,       step_d;
    logic [NUM_LEDS-1:0] led_q,        led_d;
    logic [PWM_W-1:0]    duty_q,       duty_d;
    logic                dir_down_q,   dir_down_d;
    logic [PWM_W-1:0]    pwm_q,        pwm_d;
    logic                accept;
    logic                apply;

    assign mode_ready = ready_q;
    assign led        = led_q;
    assign step       = step_q;

    // Next-state: handshake, pending apply, per-mode pattern step, PWM compare.
    always_comb begin
        mode_d       = mode_q;
        pend_mode_d  = pend_mode_q;
        pend_valid_d = pend_valid_q;
        led_d        = led_q;
        duty_d       = duty_q;
        dir_down_d   = dir_down_q;
        pwm_d        = pwm_q;
        step_d       = tick;
        accept       = mode_valid && ready_q;
        apply        = tick && pend_valid_q;

        if (enable) begin
            pwm_d = pwm_q + PWM_W'(1);
        end

        if (apply) begin
            mode_d       = pend_mode_q;
            pend_valid_d = 1'b0;
            duty_d       = '0;
            dir_down_d   = 1'b0;
            led_d        = (pend_mode_q == MODE_CHASE) ? NUM_LEDS'(1) : '0;
        end else if (tick) begin
            unique case (mode_q)
                MODE_OFF:   led_d = '0;
                MODE_BLINK: led_d = ~led_q;
                MODE_CHASE: led_d = NUM_LEDS'(led_q << 1) | NUM_LEDS'(led_q >> (NUM_LEDS - 1));
                MODE_BREATHE: begin
                    // Triangle sweep; each endpoint is visited for exactly one tick.
                    if (!dir_down_q) begin
                        duty_d = duty_q + PWM_W'(1);
                        if (duty_d == DUTY_MAX) dir_down_d = 1'b1;
                    end else begin
                        duty_d = duty_q - PWM_W'(1);
                        if (duty_d == '0) dir_down_d = 1'b0;
                    end
                end
                default: led_d = '0;
            endcase
        end

        if (mode_d == MODE_BREATHE) begin
            led_d = {NUM_LEDS{pwm_d < duty_d}};
        end

        if (accept) begin
            pend_valid_d = 1'b1;
            pend_mode_d  = led_mode_e'(mode);
        end

        ready_d = !pend_valid_d;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mode_q       <= MODE_OFF;
            pend_mode_q  <= MODE_OFF;
            pend_valid_q <= 1'b0;
            ready_q      <= 1'b1;
            step_q       <= 1'b0;
            led_q        <= '0;
            duty_q       <= '0;
            dir_down_q   <= 1'b0;
            pwm_q        <= '0;
        end else begin
            mode_q       <= mode_d;
            pend_mode_q  <= pend_mode_d;
            pend_valid_q <= pend_valid_d;
            ready_q      <= ready_d;
            step_q       <= step_d;
            led_q        <= led_d;
            duty_q       <= duty_d;
            dir_down_q   <= dir_down_d;
            pwm_q        <= pwm_d;
        end
    end

endmodule

// File: tb/tb_led_pattern_gen.sv
// Bench for led_pattern_gen: abstract reference model feeds an expectation queue,
// a negedge monitor pops and compares against the DUT outputs every cycle.
module tb_led_pattern_gen;

    localparam int N  = 4;
    localparam int TD = 4;
    localparam int W  = 3;
    localparam int DMAX = (1 << W) - 1;

    logic         clk = 1'b0;
    logic         rst;
    logic         enable;
    logic [1:0]   mode;
    logic         mode_valid;
    logic         mode_ready;
    logic [N-1:0] led;
    logic         step;

    int vectors     = 0;
    int miscompares = 0;
    int cyc         = 0;

    typedef struct packed {
        logic [N-1:0] led;
        logic         step;
        logic         ready;
    } exp_t;

    exp_t exp_q[$];

    led_pattern_gen #(
        .NUM_LEDS (N),
        .TICK_DIV (TD),
        .PWM_W    (W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .enable     (enable),
        .mode       (mode),
        .mode_valid (mode_valid),
        .mode_ready (mode_ready),
        .led        (led),
        .step       (step)
    );

    always #5 clk = ~clk;

    function automatic int tri_duty(input int k);
        int p;
        p = k % (2 * DMAX);
        return (p <= DMAX) ? p : (2 * DMAX - p);
    endfunction

    // Reference model: phase from enabled-cycle count, pattern from ticks since last apply.
    initial begin : model
        int  en_cnt;
        int  k;
        int  m_mode;
        int  p_mode;
        bit  pend;
        bit  tk;
        bit  acc;
        bit  app;
        exp_t e;
        en_cnt = 0; k = 0; m_mode = 0; p_mode = 0; pend = 0;
        forever begin
            @(posedge clk or posedge rst);
            if (rst) begin
                en_cnt = 0; k = 0; m_mode = 0; p_mode = 0; pend = 0;
                exp_q.delete();
            end else begin
                tk  = enable && ((en_cnt % TD) == TD - 1);
                acc = mode_valid && !pend;
                app = tk && pend;
                if (enable) en_cnt++;
                if (app) begin
                    m_mode = p_mode;
                    k      = 0;
                    pend   = 0;
                end else if (tk) begin
                    k++;
                end
                if (acc) begin
                    pend   = 1;
                    p_mode = int'(mode);
                end
                case (m_mode)
                    1:       e.led = (k % 2 == 1) ? '1 : '0;
                    2:       e.led = N'(1 << (k % N));
                    3:       e.led = (tri_duty(k) > (en_cnt % (DMAX + 1))) ? '1 : '0;
                    default: e.led = '0;
                endcase
                e.step  = tk;
                e.ready = !pend;
                exp_q.push_back(e);
            end
        end
    end

    // Monitor: one expected entry per clock edge, checked half a cycle later.
    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            cyc++;
            if (!rst && exp_q.size() > 0) begin
                e = exp_q.pop_front();
                vectors++;
                if (led !== e.led || step !== e.step || mode_ready !== e.ready) begin
                    miscompares++;
                    $display("FAIL outputs cyc=%0d: got led=%b step=%b ready=%b, expected led=%b step=%b ready=%b",
                             cyc, led, step, mode_ready, e.led, e.step, e.ready);
                end
            end
        end
    end

    task automatic check_reset_outputs(input string name);
        vectors++;
        if (led !== '0 || step !== 1'b0 || mode_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL %s: got led=%b step=%b ready=%b, expected led=0000 step=0 ready=1",
                     name, led, step, mode_ready);
        end
    endtask

    // Issue a request and hold valid until the DUT accepts it; called at a negedge.
    task automatic request(input logic [1:0] m);
        int guard;
        guard      = 0;
        mode_valid = 1'b1;
        mode       = m;
        while (!mode_ready && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 200) begin
            vectors++;
            miscompares++;
            $display("FAIL handshake_timeout: ready stayed 0, expected acceptance within 200 clks");
        end
        @(negedge clk);
        mode_valid = 1'b0;
    endtask

    task automatic run(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin : stim
        rst        = 1'b1;
        enable     = 1'b1;
        mode       = 2'd0;
        mode_valid = 1'b0;
        #1;
        check_reset_outputs("reset_initial");
        repeat (2) @(negedge clk);
        rst = 1'b0;
        run(6);

        request(2'd2);
        run(24);
        request(2'd1);
        run(20);
        request(2'd3);
        run(130);

        // Back-to-back requests: the second is held while ready is low.
        request(2'd2);
        request(2'd1);
        run(12);

        // Freeze mid-chase.
        request(2'd2);
        run(9);
        enable = 1'b0;
        run(10);
        enable = 1'b1;
        run(16);

        // Randomised traffic including enable gaps and ignored valids.
        for (int i = 0; i < 600; i++) begin
            enable     = ($urandom % 8) != 0;
            mode_valid = ($urandom % 6) == 0;
            mode       = 2'($urandom % 4);
            @(negedge clk);
        end
        mode_valid = 1'b0;
        enable     = 1'b1;

        // Asynchronous reset in the middle of a chase step.
        request(2'd2);
        run(7);
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check_reset_outputs("reset_async_mid");
        @(negedge clk);
        check_reset_outputs("reset_held");
        @(negedge clk);
        rst = 1'b0;
        run(20);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation still running at 500000, expected completion earlier");
        $fatal(1, "watchdog expired");
    end

endmodule
